// File: rtl/regfile_ctrl.sv
// Command sequencer for a 16 x 16-bit register file: turns WRITE/READ/COPY/FILL
// commands into cycle-exact register-file strobes and returns one response per command.
module regfile_ctrl #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_addr2,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          rf_we,
    output logic          rf_re,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata
);

    typedef enum logic [3:0] {
        IDLE, WR, RD, RD_CAP, CP_RD, CP_CAP, CP_WR, FILL, RSP
    } state_t;

    state_t        state_r, state_s;
    logic [AW-1:0] dst_r, dst_s;
    logic          rf_we_s, rf_re_s, rsp_valid_s, busy_s, accept_s;
    logic [AW-1:0] rf_addr_s;
    logic [DW-1:0] rf_wdata_s, rsp_data_s;

    assign cmd_ready = (state_r == IDLE) && !rst;
    assign accept_s  = cmd_valid && cmd_ready;

    // Next-state and next-output decode; rf_wdata doubles as the captured read value.
    always_comb begin
        state_s     = state_r;
        dst_s       = dst_r;
        rf_we_s     = 1'b0;
        rf_re_s     = 1'b0;
        rf_addr_s   = rf_addr;
        rf_wdata_s  = rf_wdata;
        rsp_valid_s = rsp_valid;
        rsp_data_s  = rsp_data;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    dst_s      = cmd_addr2;
                    rf_wdata_s = cmd_data;
                    rf_addr_s  = cmd_addr;
                    case (cmd_op)
                        2'b00: begin
                            state_s = WR;
                            rf_we_s = 1'b1;
                        end
                        2'b01: begin
                            state_s = RD;
                            rf_re_s = 1'b1;
                        end
                        2'b10: begin
                            state_s = CP_RD;
                            rf_re_s = 1'b1;
                        end
                        default: begin
                            state_s   = FILL;
                            rf_we_s   = 1'b1;
                            rf_addr_s = {AW{1'b0}};
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            WR: begin
                state_s     = RSP;
                rsp_valid_s = 1'b1;
                rsp_data_s  = rf_wdata;
            end
            RD:     state_s = RD_CAP;
            RD_CAP: begin
                state_s     = RSP;
                rsp_valid_s = 1'b1;
                rsp_data_s  = rf_rdata;
            end
            CP_RD:  state_s = CP_CAP;
            CP_CAP: begin
                state_s    = CP_WR;
                rf_we_s    = 1'b1;
                rf_addr_s  = dst_r;
                rf_wdata_s = rf_rdata;
            end
            CP_WR: begin
                state_s     = RSP;
                rsp_valid_s = 1'b1;
                rsp_data_s  = rf_wdata;
            end
            FILL: begin
                // rf_addr is the fill counter; the sweep ends after the top register
                if (rf_addr == {AW{1'b1}}) begin
                    state_s     = RSP;
                    rsp_valid_s = 1'b1;
                    rsp_data_s  = rf_wdata;
                end else begin
                    rf_we_s   = 1'b1;
                    rf_addr_s = rf_addr + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_s     = IDLE;
                    rsp_valid_s = 1'b0;
                end else begin
                    state_s = RSP;
                end
            end
            default: begin
                state_s     = IDLE;
                rsp_valid_s = 1'b0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            dst_r     <= {AW{1'b0}};
            rf_we     <= 1'b0;
            rf_re     <= 1'b0;
            rf_addr   <= {AW{1'b0}};
            rf_wdata  <= {DW{1'b0}};
            rsp_valid <= 1'b0;
            rsp_data  <= {DW{1'b0}};
            busy      <= 1'b0;
        end else begin
            state_r   <= state_s;
            dst_r     <= dst_s;
            rf_we     <= rf_we_s;
            rf_re     <= rf_re_s;
            rf_addr   <= rf_addr_s;
            rf_wdata  <= rf_wdata_s;
            rsp_valid <= rsp_valid_s;
            rsp_data  <= rsp_data_s;
            busy      <= busy_s;
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: a register-file memory attached to the rf_* port and a
// command-level reference model predicting strobe traces and responses.
module tb_regfile_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [3:0]  cmd_addr = 4'd0;
    logic [3:0]  cmd_addr2 = 4'd0;
    logic [15:0] cmd_data = 16'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        busy;
    logic        rf_we;
    logic        rf_re;
    logic [3:0]  rf_addr;
    logic [15:0] rf_wdata;
    logic [15:0] rf_rdata;

    logic [15:0] rf_mem [16];
    logic [15:0] ref_mem [16];
    int vectors = 0;
    int miscompares = 0;

    regfile_ctrl #(.DW(16), .AW(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_addr2(cmd_addr2), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .rf_we(rf_we), .rf_re(rf_re), .rf_addr(rf_addr),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // Register file with one-cycle registered read.
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_addr] <= rf_wdata;
        if (rf_re) rf_rdata <= rf_mem[rf_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 64) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] a2,
                          input logic [15:0] d, input int dly);
        int n;
        logic ew, er;
        logic [3:0] ea;
        logic [15:0] ewd, exp_rsp;
        wait_ready();
        rsp_ready = (dly == 0);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_addr = a; cmd_addr2 = a2; cmd_data = d;
        tick();
        n = (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : (op == 2'd2) ? 3 : 16;
        for (int k = 0; k < n; k++) begin
            // operands were latched; scramble inputs while busy
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op = 2'($urandom_range(0, 3));
            cmd_addr = 4'($urandom_range(0, 15));
            cmd_addr2 = 4'($urandom_range(0, 15));
            cmd_data = 16'($urandom);
            ew = 1'b0; er = 1'b0; ea = 4'd0; ewd = 16'd0;
            case (op)
                2'd0: begin ew = 1'b1; ea = a; ewd = d; end
                2'd1: if (k == 0) begin er = 1'b1; ea = a; end
                2'd2: begin
                    if (k == 0) begin er = 1'b1; ea = a; end
                    if (k == 2) begin ew = 1'b1; ea = a2; ewd = ref_mem[a]; end
                end
                default: begin ew = 1'b1; ea = 4'(k); ewd = d; end
            endcase
            check("strobes", {30'd0, rf_we, rf_re}, {30'd0, ew, er});
            check("busy_nordy", {30'd0, busy, cmd_ready, rsp_valid}, {29'd0, 3'b100});
            if (ew || er) check("rf_addr", {28'd0, rf_addr}, {28'd0, ea});
            if (ew) check("rf_wdata", {16'd0, rf_wdata}, {16'd0, ewd});
            tick();
        end
        cmd_valid = 1'b0;
        exp_rsp = (op == 2'd1 || op == 2'd2) ? ref_mem[a] : d;
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_data", {16'd0, rsp_data}, {16'd0, exp_rsp});
        check("rsp_quiet", {28'd0, busy, cmd_ready, rf_we, rf_re}, {28'd0, 4'b1000});
        for (int j = 0; j < dly; j++) begin
            cmd_valid = 1'b1;
            cmd_op = 2'($urandom_range(0, 3));
            cmd_addr = 4'($urandom_range(0, 15));
            tick();
            check("rsp_hold", {15'd0, rsp_valid, rsp_data}, {15'd0, 1'b1, exp_rsp});
            check("hold_quiet", {29'd0, cmd_ready, rf_we, rf_re}, 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("back_idle", {29'd0, rsp_valid, busy, cmd_ready}, {29'd0, 3'b001});
        rsp_ready = 1'b0;
        case (op)
            2'd0: ref_mem[a] = d;
            2'd2: ref_mem[a2] = ref_mem[a];
            2'd3: for (int i = 0; i < 16; i++) ref_mem[i] = d;
            default: ;
        endcase
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'd0;
        tick();
        tick();
        check("reset_strobes", {30'd0, rf_we, rf_re}, 32'd0);
        check("reset_status", {29'd0, busy, rsp_valid, cmd_ready}, 32'd0);
        check("reset_regs", {8'd0, rf_addr, rf_wdata[3:0], rsp_data}, 32'd0);
        check("reset_wdata", {16'd0, rf_wdata}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        do_cmd(2'd3, 4'd0, 4'd0, 16'h0000, 0);
        do_cmd(2'd0, 4'd3, 4'd0, 16'hBEEF, 0);
        do_cmd(2'd0, 4'd7, 4'd0, 16'h1234, 1);
        do_cmd(2'd1, 4'd7, 4'd0, 16'h0000, 0);
        do_cmd(2'd0, 4'd2, 4'd0, 16'hA5A5, 0);
        do_cmd(2'd2, 4'd2, 4'd9, 16'h0000, 0);
        do_cmd(2'd1, 4'd9, 4'd0, 16'h0000, 0);
        do_cmd(2'd2, 4'd9, 4'd9, 16'h0000, 2);
        do_cmd(2'd3, 4'd0, 4'd0, 16'h00FF, 0);
        do_cmd(2'd1, 4'd0, 4'd0, 16'h0000, 0);
        do_cmd(2'd1, 4'd15, 4'd0, 16'h0000, 0);
        do_cmd(2'd1, 4'd3, 4'd0, 16'h0000, 5);

        for (int t = 0; t < 40; t++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            if (op == 2'd3 && $urandom_range(0, 3) != 0) op = 2'd0;
            do_cmd(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   16'($urandom), int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 16; i++) do_cmd(2'd0, 4'(i), 4'd0, 16'h1000 + 16'(i), 0);

        // FILL interrupted by reset sampled at the edge that starts c6
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_data = 16'h5555;
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        check("fill_c5_addr", {27'd0, rf_we, rf_addr}, {27'd0, 1'b1, 4'd5});
        rst = 1'b1;
        tick();
        check("rst_mid_fill", {28'd0, rf_we, busy, rsp_valid, cmd_ready}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) ref_mem[i] = 16'h5555;
        tick();
        do_cmd(2'd1, 4'd0, 4'd0, 16'h0000, 0);
        do_cmd(2'd1, 4'd5, 4'd0, 16'h0000, 0);
        do_cmd(2'd1, 4'd6, 4'd0, 16'h0000, 0);
        do_cmd(2'd1, 4'd15, 4'd0, 16'h0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
